// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one imem request at a time, hands the instruction to decode
// over valid/ready, requests the sequential PC advance and flushes in-flight work on redirect.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [ILEN-1:0] NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault,
  output logic            pc_if_write_en,
  output logic [XLEN-1:0] pc_if_write
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StHold, StHoldFault} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [ILEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            if_fault_q, if_fault_d;
  logic            pc_wen_q, pc_wen_d;
  logic [XLEN-1:0] pc_wdata_q, pc_wdata_d;
  logic            pc_aligned;

  assign pc_aligned = (pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_fault_q <= 1'b0;
      pc_wen_q   <= 1'b0;
      pc_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_fault_q <= if_fault_d;
      pc_wen_q   <= pc_wen_d;
      pc_wdata_q <= pc_wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    if_valid_d     = if_valid_q;
    if_instr_d     = if_instr_q;
    if_pc_d        = if_pc_q;
    if_fault_d     = if_fault_q;
    pc_wen_d       = 1'b0;
    pc_wdata_d     = pc_wdata_q;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;

    unique case (state_q)
      StIdle: begin
        if (!redirect) state_d = StReq;
      end
      StReq: begin
        imem_req_addr  = pc;
        imem_req_valid = pc_aligned;
        if (!pc_aligned) begin
          if (redirect) begin
            state_d = StIdle;
          end else begin
            if_valid_d = 1'b1;
            if_fault_d = 1'b1;
            if_instr_d = NOP_INSN;
            if_pc_d    = pc;
            state_d    = StHoldFault;
          end
        end else if (imem_req_ready) begin
          req_pc_d = pc;
          // Request already accepted: its response must still be absorbed.
          state_d  = redirect ? StDrain : StWait;
        end else if (redirect) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (redirect) begin
          state_d = imem_rsp_valid ? StIdle : StDrain;
        end else if (imem_rsp_valid) begin
          if_valid_d = 1'b1;
          if_pc_d    = req_pc_q;
          if (imem_rsp_err) begin
            if_instr_d = NOP_INSN;
            if_fault_d = 1'b1;
            state_d    = StHoldFault;
          end else begin
            if_instr_d = imem_rsp_data;
            if_fault_d = 1'b0;
            pc_wen_d   = 1'b1;
            pc_wdata_d = req_pc_q + XLEN'(4);
            state_d    = StHold;
          end
        end
      end
      StDrain: begin
        // Orphan response arriving together with another redirect: nothing left to wait for.
        if (imem_rsp_valid) state_d = redirect ? StIdle : StReq;
      end
      StHold: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      StHoldFault: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (if_valid_q && if_ready) begin
          if_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_fault       = if_fault_q;
  assign pc_if_write_en = pc_wen_q;
  assign pc_if_write    = pc_wdata_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a PC register, a one-deep memory with random latency
// and a transaction-level scoreboard predicting what decode and the PC block must observe.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc;
  logic [63:0] reset_pc = 64'h1000;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_fault;
  logic        pc_if_write_en;
  logic [63:0] pc_if_write;

  int n_chk  = 0;
  int n_pass = 0;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault),
    .pc_if_write_en (pc_if_write_en),
    .pc_if_write    (pc_if_write)
  );

  always #5 clk = ~clk;

  // Architectural PC register: an override write wins over the sequential update.
  always_ff @(posedge clk) begin
    if (rst) pc <= reset_pc;
    else if (redirect) pc <= redirect_pc;
    else if (pc_if_write_en) pc <= pc_if_write;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard state
  bit          outst, live;        // a request is in memory; it has not been cancelled
  logic [63:0] out_addr;
  bit          vis;                // an instruction must be on the decode interface
  logic [31:0] e_instr;
  logic [63:0] e_pc;
  bit          e_fault;
  bit          locked;             // fault consumed, nothing may happen until a redirect
  bit          pulse;
  logic [63:0] pulse_val;
  bit          after_accept;
  bit          cand;               // previous cycle could have produced a misaligned fault
  logic [63:0] cand_pc;
  int          idle_cnt;
  bit          mem_busy, stale_rsp;
  int          mem_cnt;

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    int r;
    r = $urandom_range(15);
    t = {32'h0, $urandom} & ~64'h3;
    if (r == 0) t = 64'hFFFF_FFFF_FFFF_FFFC;
    else if (r < 3) t = t | 64'($urandom_range(3, 1));
    return t;
  endfunction

  task automatic clear_model();
    outst = 0; live = 0; vis = 0; locked = 0; pulse = 0; after_accept = 0;
    cand = 0; idle_cnt = 0; mem_busy = 0; mem_cnt = 0;
  endtask

  task automatic do_reset(input logic [63:0] start_pc);
    @(negedge clk);
    rst = 1'b1; reset_pc = start_pc; redirect = 1'b0;
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_fault", if_fault, 0);
    chk("rst_wen", pc_if_write_en, 0);
    chk("rst_wdata", pc_if_write, 0);
    clear_model();
    stale_rsp = 1;
    rst = 1'b0;
  endtask

  task automatic step();
    bit idle, vis_old;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (stale_rsp) begin
      // Leftover response from before reset; fetch must ignore it.
      imem_rsp_valid = 1'b1; imem_rsp_data = $urandom; imem_rsp_err = 1'($urandom_range(1));
      stale_rsp = 0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = ($urandom_range(7) == 0);
        mem_busy       = 0;
      end
    end
    redirect       = ($urandom_range(9) == 0);
    redirect_pc    = pick_target();
    imem_req_ready = ($urandom_range(3) != 0);
    if_ready       = ($urandom_range(2) != 0);
    #1;

    if (if_valid && !vis) begin
      chk("misaligned_fault_expected", cand, 1);
      vis = 1; e_instr = NOP; e_pc = cand_pc; e_fault = 1;
    end
    chk("if_valid", if_valid, vis);
    if (vis) begin
      chk("if_instr", if_instr, e_instr);
      chk("if_pc", if_pc, e_pc);
      chk("if_fault", if_fault, e_fault);
    end
    chk("pc_if_write_en", pc_if_write_en, pulse);
    if (pulse) chk("pc_if_write", pc_if_write, pulse_val);
    if (after_accept) chk("req_after_accept", imem_req_valid, pc[1:0] == 2'b00);
    if (outst || vis || locked) chk("req_while_busy", imem_req_valid, 0);
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, pc);
      chk("req_align", pc[1:0], 0);
    end

    idle = !outst && !vis && !locked;
    if (redirect || !idle || imem_req_valid) idle_cnt = 0;
    else idle_cnt++;
    if (idle_cnt > 2) begin
      chk("fetch_stalled", idle_cnt, 2);
      idle_cnt = 0;
    end

    // Effects of this cycle at the coming clock edge
    vis_old      = vis;
    cand         = idle && !redirect && (pc[1:0] != 2'b00);
    cand_pc      = pc;
    pulse        = 0;
    after_accept = 0;
    if (vis_old) begin
      if (redirect) vis = 0;
      else if (if_ready) begin
        vis = 0;
        if (e_fault) locked = 1;
        else after_accept = 1;
      end
    end
    if (imem_rsp_valid && outst) begin
      outst = 0;
      if (live && !redirect) begin
        vis = 1; e_pc = out_addr;
        if (imem_rsp_err) begin
          e_instr = NOP; e_fault = 1;
        end else begin
          e_instr = imem_rsp_data; e_fault = 0;
          pulse = 1; pulse_val = out_addr + 64'd4;
        end
      end
    end
    if (redirect) begin
      live   = 0;
      locked = 0;
    end
    if (imem_req_valid && imem_req_ready) begin
      outst    = 1;
      live     = !redirect;
      out_addr = imem_req_addr;
      mem_busy = 1;
      mem_cnt  = $urandom_range(3, 1);
    end
  endtask

  initial begin
    do_reset(64'h1000);
    repeat (1500) step();
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    repeat (1500) step();
    do_reset(64'h1002);
    repeat (1500) step();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
